local_bus_initiator: RTL

- 68040-style local bus master for CLK40-domain clients such as the PCI bridge and DMA.
- Accepts one request at a time from an internal client.
- Runs a single-beat or 4-beat line transfer: drives nTS, address, RnW, SIZ and TT, then waits for nTA/nTEA from the address-decode/transfer-ack responder.
- Returns read data and a completion/error status to the client.
- Falls back to single-beat transfers when the responder asserts nTBI.

---
 rtl/local_bus_initiator.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/local_bus_initiator.sv
// 68040-style local bus initiator: one client request at a time, single-beat or 4-beat line transfers
// with retry, bus error and burst-inhibit fallback. Optional termination timeout: LOCAL_BUS_TIMEOUT_EN.
`timescale 1ns/1ps
module local_bus_initiator #(
`ifdef LOCAL_BUS_TIMEOUT_EN
    parameter int         TIMEOUT_CYCLES = 255,
`endif
    parameter logic [1:0] TT_NORMAL      = 2'b00
) (
    input  logic        CLK40,
    input  logic        TS_RESET,
    input  logic        REQ,
    input  logic        REQ_RNW,
    input  logic        REQ_LINE,
    input  logic [1:0]  REQ_SIZ,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        BEAT_DONE,
    output logic        DONE,
    output logic        ERR,
    output logic        BUSY,
    output logic        nTS,
    output logic        nTIP,
    output logic [31:0] A,
    output logic        RnW,
    output logic [1:0]  SIZ,
    output logic        TT0,
    output logic        TT1,
    output logic [31:0] D_OUT,
    output logic        D_OE,
    input  logic [31:0] D_IN,
    input  logic        nTA,
    input  logic        nTEA,
    input  logic        nTBI
);

    typedef enum logic [2:0] {IDLE, START, WAIT, BURST, RESTART, FINISH} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [31:0] rdata_q;
    logic        rnw_q;
    logic        line_q;
    logic        inhibit_q;
    logic [1:0]  siz_q;
    logic [1:0]  beat_cnt;
    logic        beat_done_q;
    logic        err_q;
    logic        beat_take;
    logic        go_inhibit;
    logic        err_nxt;
    logic        timeout_hit;
    logic        term_beat;
    logic        term_err;
    logic        term_retry;

    assign term_beat  = !nTA &&  nTEA;
    assign term_err   =  nTA && !nTEA;
    assign term_retry = !nTA && !nTEA;

`ifdef LOCAL_BUS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] timeout_cnt;

    // Loaded with 1 at every nTS so the error lands exactly TIMEOUT_CYCLES after the start cycle
    always_ff @(posedge CLK40 or posedge TS_RESET) begin
        if (TS_RESET)
            timeout_cnt <= '0;
        else if (state == START)
            timeout_cnt <= 16'd1;
        else if (state == WAIT || state == BURST)
            timeout_cnt <= timeout_cnt + 16'd1;
    end

    assign timeout_hit = (state == WAIT || state == BURST) && (timeout_cnt >= TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLK40 or posedge TS_RESET) begin
        if (TS_RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Retry outranks everything; nTBI only matters on the first beat of a line transfer
    always_comb begin
        state_nxt  = state;
        beat_take  = 1'b0;
        go_inhibit = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            IDLE:    if (REQ) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT, BURST: begin
                if (term_retry) begin
                    state_nxt = START;
                end else if (term_err) begin
                    state_nxt = FINISH;
                    err_nxt   = 1'b1;
                end else if (term_beat) begin
                    beat_take = 1'b1;
                    if (!line_q || beat_cnt == 2'd3) begin
                        state_nxt = FINISH;
                    end else if (inhibit_q || (beat_cnt == 2'd0 && !nTBI)) begin
                        state_nxt  = RESTART;
                        go_inhibit = 1'b1;
                    end else begin
                        state_nxt = BURST;
                    end
                end else if (timeout_hit) begin
                    state_nxt = FINISH;
                    err_nxt   = 1'b1;
                end
            end
            RESTART: state_nxt = START;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK40 or posedge TS_RESET) begin
        if (TS_RESET) begin
            addr_q      <= '0;
            rdata_q     <= '0;
            rnw_q       <= 1'b1;
            line_q      <= 1'b0;
            inhibit_q   <= 1'b0;
            siz_q       <= 2'b00;
            beat_cnt    <= 2'd0;
            beat_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            beat_done_q <= beat_take;
            err_q       <= err_nxt;
            if (state == IDLE && REQ) begin
                addr_q    <= REQ_ADDR;
                rnw_q     <= REQ_RNW;
                line_q    <= REQ_LINE;
                siz_q     <= REQ_LINE ? 2'b11 : REQ_SIZ;
                inhibit_q <= 1'b0;
                beat_cnt  <= 2'd0;
            end
            if (beat_take) begin
                beat_cnt <= beat_cnt + 2'd1;
                if (rnw_q)
                    rdata_q <= D_IN;
                if (line_q)
                    addr_q[3:2] <= addr_q[3:2] + 2'd1;
            end
            // Burst inhibited: the remaining beats go out as separate long transfers
            if (go_inhibit) begin
                inhibit_q <= 1'b1;
                siz_q     <= 2'b00;
            end
        end
    end

    assign nTS       = (state != START);
    assign nTIP      = (state == IDLE);
    assign BUSY      = (state != IDLE);
    assign DONE      = (state == FINISH);
    assign ERR       = err_q;
    assign BEAT_DONE = beat_done_q;
    assign RDATA     = rdata_q;
    assign A         = addr_q;
    assign RnW       = rnw_q;
    assign SIZ       = siz_q;
    assign TT0       = TT_NORMAL[0];
    assign TT1       = TT_NORMAL[1];
    assign D_OE      = !rnw_q && (state != IDLE);
    assign D_OUT     = D_OE ? WDATA : 32'h0;

endmodule
